// File: rtl/exu_alu_issue_pkg.sv
// Shared encodings for the execute-stage ALU sequencer: ALU opcodes, branch
// types, FSM states and a small branch-classification helper.
package exu_alu_issue_pkg;

  localparam logic [3:0] ALU_OP_ADD           = 4'd0;
  localparam logic [3:0] ALU_OP_SUB           = 4'd1;
  localparam logic [3:0] ALU_OP_AND           = 4'd2;
  localparam logic [3:0] ALU_OP_OR            = 4'd3;
  localparam logic [3:0] ALU_OP_XOR           = 4'd4;
  localparam logic [3:0] ALU_OP_SLL           = 4'd5;
  localparam logic [3:0] ALU_OP_SRL           = 4'd6;
  localparam logic [3:0] ALU_OP_SRA           = 4'd7;
  localparam logic [3:0] ALU_OP_LESS_SIGNED   = 4'd8;
  localparam logic [3:0] ALU_OP_LESS_UNSIGNED = 4'd9;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_cond_br(input logic [2:0] br);
    return (br != BR_NONE) && (br != BR_JUMP);
  endfunction

endpackage

// File: rtl/exu_branch_resolve.sv
// Combinational branch/jump resolution: taken decision from the ALU flags,
// redirect target and link value (pc+4) for the execute stage.
module exu_branch_resolve
  import exu_alu_issue_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [2:0]          br_type,
  input  logic                less,
  input  logic                zero,
  input  logic [DATA_LEN-1:0] pc,
  input  logic [DATA_LEN-1:0] imm,
  input  logic [DATA_LEN-1:0] alu_result,
  output logic                taken,
  output logic [DATA_LEN-1:0] target,
  output logic [DATA_LEN-1:0] link
);

  logic [DATA_LEN-1:0] br_target;

  // Conditional branches use their own adder because the ALU is busy comparing.
  assign br_target = pc + imm;
  assign link      = pc + DATA_LEN'(4);

  always_comb begin
    taken  = 1'b0;
    target = br_target;
    case (br_type)
      BR_BEQ:           taken = zero;
      BR_BNE:           taken = !zero;
      BR_BLT, BR_BLTU:  taken = less;
      BR_BGE, BR_BGEU:  taken = !less;
      BR_JUMP: begin
        taken  = 1'b1;
        target = {alu_result[DATA_LEN-1:1], 1'b0};
      end
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/exu_alu_issue.sv
// Execute-stage sequencer: latches one decoded instruction, drives the external
// combinational ALU for one cycle, and holds the resolved result for writeback.
module exu_alu_issue
  import exu_alu_issue_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int RD_W     = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_pc,
  input  logic [DATA_LEN-1:0] in_rs1,
  input  logic [DATA_LEN-1:0] in_rs2,
  input  logic [DATA_LEN-1:0] in_imm,
  input  logic                in_src1_pc,
  input  logic                in_src2_imm,
  input  logic [3:0]          in_alu_op,
  input  logic [2:0]          in_br_type,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                in_wen,
  output logic [DATA_LEN-1:0] alu_src1,
  output logic [DATA_LEN-1:0] alu_src2,
  output logic [3:0]          alu_control,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic                alu_less_i,
  input  logic                alu_zero_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_result,
  output logic [RD_W-1:0]     out_rd,
  output logic                out_wen,
  output logic                out_redirect,
  output logic [DATA_LEN-1:0] out_redirect_pc,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready depends combinationally on out_ready so a finishing result and
  // the next instruction can hand over in the same cycle.

  state_t              state;
  logic [DATA_LEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic                src1_pc_q, src2_imm_q, wen_q;
  logic [3:0]          op_q;
  logic [2:0]          br_q;
  logic [RD_W-1:0]     rd_q;
  logic                accept, cond_br, taken;
  logic [DATA_LEN-1:0] target, link;

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign cond_br   = is_cond_br(br_q);
  assign dbg_state = state;

  // Conditional branches always compare rs1 against rs2.
  assign alu_src1 = (src1_pc_q && !cond_br) ? pc_q : rs1_q;
  assign alu_src2 = (src2_imm_q && !cond_br) ? imm_q : rs2_q;

  always_comb begin
    case (br_q)
      BR_BEQ, BR_BNE:   alu_control = ALU_OP_SUB;
      BR_BLT, BR_BGE:   alu_control = ALU_OP_LESS_SIGNED;
      BR_BLTU, BR_BGEU: alu_control = ALU_OP_LESS_UNSIGNED;
      default:          alu_control = op_q;
    endcase
  end

  exu_branch_resolve #(.DATA_LEN(DATA_LEN)) u_branch_resolve (
    .br_type    (br_q),
    .less       (alu_less_i),
    .zero       (alu_zero_i),
    .pc         (pc_q),
    .imm        (imm_q),
    .alu_result (alu_result_i),
    .taken      (taken),
    .target     (target),
    .link       (link)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      pc_q            <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      imm_q           <= '0;
      src1_pc_q       <= 1'b0;
      src2_imm_q      <= 1'b0;
      op_q            <= '0;
      br_q            <= '0;
      rd_q            <= '0;
      wen_q           <= 1'b0;
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_rd          <= '0;
      out_wen         <= 1'b0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= '0;
    end else begin
      if (accept) begin
        pc_q       <= in_pc;
        rs1_q      <= in_rs1;
        rs2_q      <= in_rs2;
        imm_q      <= in_imm;
        src1_pc_q  <= in_src1_pc;
        src2_imm_q <= in_src2_imm;
        op_q       <= in_alu_op;
        br_q       <= in_br_type;
        rd_q       <= in_rd;
        wen_q      <= in_wen;
      end
      case (state)
        S_IDLE: if (accept) state <= S_EXEC;
        S_EXEC: begin
          state           <= S_DONE;
          out_valid       <= 1'b1;
          out_result      <= (br_q == BR_JUMP) ? link : (cond_br ? '0 : alu_result_i);
          out_rd          <= rd_q;
          out_wen         <= wen_q && !cond_br;
          out_redirect    <= taken;
          out_redirect_pc <= target;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? S_EXEC : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_alu_issue.sv
// Directed self-checking bench for exu_alu_issue with a behavioural ALU
// attached and an expected-result queue checked at each output transfer.
module tb_exu_alu_issue;
  import exu_alu_issue_pkg::*;

  localparam int DATA_LEN = 32;
  localparam int RD_W     = 5;
  localparam int EXP_W    = DATA_LEN + RD_W + 2 + DATA_LEN;

  typedef struct packed {
    logic [DATA_LEN-1:0] result;
    logic [RD_W-1:0]     rd;
    logic                wen;
    logic                redirect;
    logic [DATA_LEN-1:0] rpc;
  } exp_t;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic                in_src1_pc = 1'b0, in_src2_imm = 1'b0;
  logic [3:0]          in_alu_op = '0;
  logic [2:0]          in_br_type = '0;
  logic [RD_W-1:0]     in_rd = '0;
  logic                in_wen = 1'b0;
  logic [DATA_LEN-1:0] alu_src1, alu_src2, alu_result;
  logic [3:0]          alu_control;
  logic                alu_less, alu_zero;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [DATA_LEN-1:0] out_result, out_redirect_pc;
  logic [RD_W-1:0]     out_rd;
  logic                out_wen, out_redirect;
  logic [1:0]          dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  exp_t             mon_e;
  int               n_checks = 0;
  int               n_pass   = 0;

  exu_alu_issue #(.DATA_LEN(DATA_LEN), .RD_W(RD_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_src1_pc(in_src1_pc), .in_src2_imm(in_src2_imm),
    .in_alu_op(in_alu_op), .in_br_type(in_br_type), .in_rd(in_rd), .in_wen(in_wen),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_control(alu_control),
    .alu_result_i(alu_result), .alu_less_i(alu_less), .alu_zero_i(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
    .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc),
    .dbg_state(dbg_state)
  );

  // Clock/reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  // Behavioural ALU seen by the DUT
  always_comb begin
    case (alu_control)
      ALU_OP_ADD:           alu_result = alu_src1 + alu_src2;
      ALU_OP_SUB:           alu_result = alu_src1 - alu_src2;
      ALU_OP_XOR:           alu_result = alu_src1 ^ alu_src2;
      ALU_OP_LESS_SIGNED:   alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
      ALU_OP_LESS_UNSIGNED: alu_result = {31'b0, alu_src1 < alu_src2};
      default:              alu_result = '0;
    endcase
    alu_less = (alu_control == ALU_OP_LESS_SIGNED) ? ($signed(alu_src1) < $signed(alu_src2))
                                                   : (alu_src1 < alu_src2);
    alu_zero = (alu_src1 == alu_src2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_in(input logic [31:0] pc, rs1, rs2, imm, input logic s1pc, s2imm,
                          input logic [3:0] op, input logic [2:0] br,
                          input logic [4:0] rd, input logic wen);
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_src1_pc = s1pc; in_src2_imm = s2imm;
    in_alu_op = op; in_br_type = br; in_rd = rd; in_wen = wen;
    in_valid = 1'b1;
  endtask

  // Returns one cycle after the accepting edge, i.e. with the DUT in S_EXEC.
  task automatic send(input logic [31:0] pc, rs1, rs2, imm, input logic s1pc, s2imm,
                      input logic [3:0] op, input logic [2:0] br,
                      input logic [4:0] rd, input logic wen);
    int n;
    drive_in(pc, rs1, rs2, imm, s1pc, s2imm, op, br, rd, wen);
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] result, input logic [4:0] rd,
                          input logic wen, redirect, input logic [31:0] rpc);
    exp_t e;
    e = '{result: result, rd: rd, wen: wen, redirect: redirect, rpc: rpc};
    exp_q.push_back(e);
  endtask

  // After send(): S_EXEC now, result visible next cycle, back to idle after that.
  task automatic finish_op(input string tag);
    check({tag, "_exec_state"}, dbg_state, S_EXEC);
    check({tag, "_exec_no_valid"}, out_valid, 0);
    step();
    check({tag, "_valid_n2"}, out_valid, 1);
    step();
  endtask

  // Scoreboard: compare at every output transfer
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_valid, 0);
      end else begin
        mon_e = exp_t'(exp_q.pop_front());
        check("out_result", out_result, mon_e.result);
        check("out_rd", out_rd, mon_e.rd);
        check("out_wen", out_wen, mon_e.wen);
        check("out_redirect", out_redirect, mon_e.redirect);
        if (mon_e.redirect) check("out_redirect_pc", out_redirect_pc, mon_e.rpc);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_out_redirect", out_redirect, 0);
    check("rst_alu_src1", alu_src1, 0);
    check("rst_alu_src2", alu_src2, 0);
    check("rst_alu_control", alu_control, 0);

    // ADD 5+7
    push_exp(32'd12, 5'd3, 1'b1, 1'b0, 32'h0);
    send(32'h0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, ALU_OP_ADD, BR_NONE, 5'd3, 1'b1);
    check("add_src1", alu_src1, 32'd5);
    check("add_src2", alu_src2, 32'd7);
    check("add_ctrl", alu_control, ALU_OP_ADD);
    finish_op("add");
    check("add_idle_ready", in_ready, 1);

    // BLT signed: -1 < 1 taken; src2_imm must be overridden to rs2
    push_exp(32'h0, 5'd5, 1'b0, 1'b1, 32'h8000_0010);
    send(32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 1'b1, ALU_OP_ADD, BR_BLT, 5'd5, 1'b1);
    check("blt_ctrl", alu_control, ALU_OP_LESS_SIGNED);
    check("blt_src2", alu_src2, 32'd1);
    finish_op("blt");

    // BLTU same operands: 0xFFFFFFFF < 1 unsigned is false
    push_exp(32'h0, 5'd5, 1'b0, 1'b0, 32'h0);
    send(32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 1'b1, ALU_OP_ADD, BR_BLTU, 5'd5, 1'b1);
    check("bltu_ctrl", alu_control, ALU_OP_LESS_UNSIGNED);
    finish_op("bltu");

    // BEQ / BNE equal operands
    push_exp(32'h0, 5'd2, 1'b0, 1'b1, 32'h120);
    send(32'h100, 32'h1234, 32'h1234, 32'h20, 1'b0, 1'b0, ALU_OP_ADD, BR_BEQ, 5'd2, 1'b1);
    check("beq_ctrl", alu_control, ALU_OP_SUB);
    finish_op("beq");
    push_exp(32'h0, 5'd2, 1'b0, 1'b0, 32'h0);
    send(32'h100, 32'h1234, 32'h1234, 32'h20, 1'b0, 1'b0, ALU_OP_ADD, BR_BNE, 5'd2, 1'b1);
    check("bne_ctrl", alu_control, ALU_OP_SUB);
    finish_op("bne");

    // BGE taken with target wrapping past 2^32
    push_exp(32'h0, 5'd9, 1'b0, 1'b1, 32'h10);
    send(32'hFFFF_FFF0, 32'd3, 32'd3, 32'h20, 1'b0, 1'b0, ALU_OP_ADD, BR_BGE, 5'd9, 1'b1);
    finish_op("bge");

    // JALR: target bit0 cleared, link pc+4
    push_exp(32'h8000_0104, 5'd1, 1'b1, 1'b1, 32'h8000_1002);
    send(32'h8000_0100, 32'h8000_1003, 32'h0, 32'h0, 1'b0, 1'b1, ALU_OP_ADD, BR_JUMP, 5'd1, 1'b1);
    check("jalr_src1", alu_src1, 32'h8000_1003);
    check("jalr_src2", alu_src2, 32'h0);
    finish_op("jalr");

    // JAL at top of address space: target and link both wrap
    push_exp(32'h0, 5'd1, 1'b1, 1'b1, 32'h4);
    send(32'hFFFF_FFFC, 32'h55, 32'h0, 32'h8, 1'b1, 1'b1, ALU_OP_ADD, BR_JUMP, 5'd1, 1'b1);
    check("jal_src1", alu_src1, 32'hFFFF_FFFC);
    finish_op("jal");

    // pc+imm through the ALU, write disabled
    push_exp(32'h1800, 5'd10, 1'b0, 1'b0, 32'h0);
    send(32'h1000, 32'h0, 32'h0, 32'h800, 1'b1, 1'b1, ALU_OP_ADD, BR_NONE, 5'd10, 1'b0);
    finish_op("auipc");

    // Backpressure: A held in S_DONE while B waits
    push_exp(32'd30, 5'd4, 1'b1, 1'b0, 32'h0);
    push_exp(32'd42, 5'd6, 1'b1, 1'b0, 32'h0);
    send(32'h0, 32'd10, 32'd20, 32'h0, 1'b0, 1'b0, ALU_OP_ADD, BR_NONE, 5'd4, 1'b1);
    out_ready = 1'b0;
    drive_in(32'h0, 32'd50, 32'd8, 32'h0, 1'b0, 1'b0, ALU_OP_SUB, BR_NONE, 5'd6, 1'b1);
    check("bp_exec_in_ready", in_ready, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_result", out_result, 32'd30);
      check("bp_hold_rd", out_rd, 5'd4);
      check("bp_hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    finish_op("bp_second");

    // Reset while in S_EXEC drops the instruction
    send(32'h0, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, ALU_OP_ADD, BR_NONE, 5'd7, 1'b1);
    check("rmid_exec_state", dbg_state, S_EXEC);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rmid_out_valid", out_valid, 0);
    check("rmid_in_ready", in_ready, 1);
    check("rmid_state", dbg_state, S_IDLE);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rmid_no_output", out_valid, 0);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exu_alu_issue.md
Name: exu_alu_issue

Overview:
- Execute-stage sequencer that owns the initiator side of the combinational ALU.
- Accepts one decoded instruction per valid/ready handshake and latches its operands.
- Drives src1/src2/alu_control into the ALU, captures result, less and zero, and resolves branch/jump redirects.
- Presents a registered result to writeback through a valid/ready handshake; sits between IDU and LSU/WBU.

Parameters:
DATA_LEN, 32, datapath width; must match the ALU.
RD_W, 5, destination register index width.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  decoded instruction valid.
in_ready  out  1  block can accept an instruction this cycle.
in_pc  in  DATA_LEN  instruction PC.
in_rs1  in  DATA_LEN  rs1 read data.
in_rs2  in  DATA_LEN  rs2 read data.
in_imm  in  DATA_LEN  sign-extended immediate.
in_src1_pc  in  1  1: src1=pc, 0: src1=rs1.
in_src2_imm  in  1  1: src2=imm, 0: src2=rs2.
in_alu_op  in  4  ALU opcode from the shared define file.
in_br_type  in  3  BR_NONE/BEQ/BNE/BLT/BGE/BLTU/BGEU/JUMP.
in_rd  in  RD_W  destination register.
in_wen  in  1  register write enable.
alu_src1  out  DATA_LEN  ALU operand 1.
alu_src2  out  DATA_LEN  ALU operand 2.
alu_control  out  4  ALU opcode.
alu_result_i  in  DATA_LEN  ALU result.
alu_less_i  in  1  ALU less/borrow flag.
alu_zero_i  in  1  ALU zero flag (src1==src2).
out_valid  out  1  registered result valid.
out_ready  in  1  downstream accepts.
out_result  out  DATA_LEN  value for rd.
out_rd  out  RD_W  destination register.
out_wen  out  1  write enable, forced 0 for conditional branches.
out_redirect  out  1  PC redirect required.
out_redirect_pc  out  DATA_LEN  redirect target.

Behaviour:
- FSM states: S_IDLE, S_EXEC, S_DONE.
- Reset: state=S_IDLE; every out_* = 0; operand registers = 0; alu_* outputs = 0. Reset asserted in any state discards the in-flight instruction with no partial output.
- in_ready = (state==S_IDLE) | (state==S_DONE & out_ready).
- Accept = in_valid & in_ready. On accept: latch pc, rs1, rs2, imm, selects, op, br_type, rd and wen; go to S_EXEC.
- S_EXEC (exactly 1 cycle):
  - ALU driven only from latched registers, never from in_*.
  - Capture outputs into the out_* registers; go to S_DONE.
- S_DONE:
  - out_valid=1; out_* held stable until out_ready.
  - out_ready & accept → S_EXEC; out_ready & no accept → S_IDLE; otherwise stay.
- Latency and throughput: accept at cycle N → out_valid at N+2. Back-to-back throughput is 1 instruction per 2 cycles.
- Operand mux: alu_src1 = src1_pc ? pc : rs1; alu_src2 = src2_imm ? imm : rs2.
- alu_control override for conditional branches (operands forced to rs1/rs2):
  - BEQ/BNE → ALU_OP_SUB.
  - BLT/BGE → ALU_OP_LESS_SIGNED.
  - BLTU/BGEU → ALU_OP_LESS_UNSIGNED.
  - All other br_type values use the latched op.
- Taken condition:
  - BEQ: zero; BNE: !zero.
  - BLT/BLTU: less; BGE/BGEU: !less.
  - JUMP: 1; NONE: 0.
- Redirect target:
  - Conditional branch: pc+imm from a dedicated adder, truncated to DATA_LEN (wraps modulo 2^DATA_LEN).
  - JUMP: alu_result_i with bit0 cleared (covers JAL with pc+imm and JALR with rs1+imm).
- out_result:
  - JUMP: pc+4 (wraps).
  - Conditional branch: 0.
  - Otherwise: alu_result_i.
- out_wen = in_wen & (br_type ∈ {NONE, JUMP}).
- in_valid low while S_DONE stalls: no effect. in_* changing while not accepted: ignored.

Decomposition:
- Shared package/define file holds BR_* codes (3-bit) and reuses the existing ALU_OP_* constants; no new ALU codes.
- One natural sub-module: exu_branch_resolve, combinational. It takes br_type, less, zero, pc, imm and alu_result and returns taken, target and link value.
- The FSM and registers stay in the top.

Test Plan:
- ADD: rs1=5, rs2=7, op=ADD, rd=3, wen=1 accepted at N → out_valid at N+2; result=12, rd=3, wen=1, redirect=0.
- BLT signed: rs1=0xFFFFFFFF, rs2=1, pc=0x80000000, imm=0x10 → redirect=1, pc=0x80000010, wen=0. Same operands with BLTU → redirect=0.
- BEQ: rs1=rs2=0x1234 → redirect=1. BNE with the same operands → redirect=0. Confirm alu_control=SUB during S_EXEC in both cases.
- JALR: rs1=0x80001003, imm=0, src2_imm=1, op=ADD, pc=0x80000100 → redirect_pc=0x80001002, result=0x80000104, wen=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. out_* stays stable and in_ready=0. Raise out_ready → second instruction accepted that cycle; its out_valid follows 2 cycles later.
- Reset mid-op: assert reset in S_EXEC → next cycle out_valid=0, in_ready=1, and no result is emitted for the dropped instruction.
